seven_seg_scanner: RTL

Time-multiplexed driver for a bank of common-anode 7-segment digits sharing a single segment bus. It holds a tear-free shadow copy of a packed BCD value and cycles through the digits, one refresh slot each. In every slot it feeds one nibble through the digit-to-segment `encoder` and asserts that digit's active-low anode. It sits between the counter/datapath logic and the board's display pins.

---
 rtl/seven_seg_scanner.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/seven_seg_scanner.sv
// Multiplexed common-anode 7-segment driver with a frame-aligned, tear-free shadow of a packed BCD value.
// Loads become visible at the next frame boundary (<= DIGITS*REFRESH_DIV cycles); no backpressure, last load wins.
module encoder (
    input  logic [3:0] nibble,
    output logic [7:0] seg
);
    always_comb begin
        case (nibble)
            4'd0:    seg = 8'hC0;
            4'd1:    seg = 8'hF9;
            4'd2:    seg = 8'hA4;
            4'd3:    seg = 8'hB0;
            4'd4:    seg = 8'h99;
            4'd5:    seg = 8'h92;
            4'd6:    seg = 8'h82;
            4'd7:    seg = 8'hF8;
            4'd8:    seg = 8'h80;
            4'd9:    seg = 8'h90;
            default: seg = 8'hFF;
        endcase
    end
endmodule

module seven_seg_scanner #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int GAP_CYCLES  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_mask,
    input  logic                  lz_blank,
    output logic [DIGITS-1:0]     anode,
    output logic [7:0]            seg,
    output logic                  load_ack
);
    localparam int IDX_W = $clog2(DIGITS);
    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    typedef enum logic {GAP, SHOW} state_t;
    localparam state_t START = (GAP_CYCLES == 0) ? SHOW : GAP;

    logic [4*DIGITS-1:0] pend_value, shd_value, shd_value_nxt;
    logic [DIGITS-1:0]   pend_dp, shd_dp, shd_dp_nxt;
    logic                pend_lz, shd_lz, shd_lz_nxt;
    logic                pending;
    logic [IDX_W-1:0]    idx, idx_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    state_t              state, state_nxt;

    logic                last_cyc, wrap, blank;
    logic [DIGITS-1:0]   blank_mask;
    logic [3:0]          cur_nib;
    logic [7:0]          enc_seg;
    logic [DIGITS-1:0]   anode_nxt;
    logic [7:0]          seg_nxt;

    assign last_cyc = (cnt == CNT_W'(REFRESH_DIV - 1));
    assign wrap     = last_cyc && (idx == IDX_W'(DIGITS - 1));

    always_comb begin
        cnt_nxt = last_cyc ? '0 : cnt + 1'b1;
        idx_nxt = idx;
        if (last_cyc)
            idx_nxt = (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
        state_nxt = (cnt_nxt < CNT_W'(GAP_CYCLES)) ? GAP : SHOW;
    end

    // Outputs are registered from next-state values so anode/seg line up with cnt/idx/state.
    always_comb begin
        shd_value_nxt = shd_value;
        shd_dp_nxt    = shd_dp;
        shd_lz_nxt    = shd_lz;
        if (wrap && pending) begin
            shd_value_nxt = pend_value;
            shd_dp_nxt    = pend_dp;
            shd_lz_nxt    = pend_lz;
        end
    end

    // blank_mask[i]: nibbles i..DIGITS-1 are all zero; digit 0 is never a leading zero.
    always_comb begin
        logic acc;
        acc        = 1'b1;
        blank_mask = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            acc           = acc && (shd_value_nxt[4*i +: 4] == 4'd0);
            blank_mask[i] = acc;
        end
    end

    assign cur_nib = shd_value_nxt[{idx_nxt, 2'b00} +: 4];
    assign blank   = shd_lz_nxt && blank_mask[idx_nxt];

    encoder u_enc (
        .nibble (cur_nib),
        .seg    (enc_seg)
    );

    always_comb begin
        anode_nxt = '1;
        seg_nxt   = 8'hFF;
        if (state_nxt == SHOW) begin
            anode_nxt = ~(DIGITS'(1) << idx_nxt);
            if (!blank)
                seg_nxt = {enc_seg[7] & ~shd_dp_nxt[idx_nxt], enc_seg[6:0]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_value <= '0;
            pend_dp    <= '0;
            pend_lz    <= 1'b0;
            pending    <= 1'b0;
            shd_value  <= '0;
            shd_dp     <= '0;
            shd_lz     <= 1'b0;
            idx        <= '0;
            cnt        <= '0;
            state      <= START;
            anode      <= '1;
            seg        <= 8'hFF;
            load_ack   <= 1'b0;
        end else begin
            cnt       <= cnt_nxt;
            idx       <= idx_nxt;
            state     <= state_nxt;
            shd_value <= shd_value_nxt;
            shd_dp    <= shd_dp_nxt;
            shd_lz    <= shd_lz_nxt;
            anode     <= anode_nxt;
            seg       <= seg_nxt;
            load_ack  <= wrap && pending;
            // A load on the boundary edge refills the buffer after the shadow took the old one.
            if (load) begin
                pend_value <= value;
                pend_dp    <= dp_mask;
                pend_lz    <= lz_blank;
                pending    <= 1'b1;
            end else if (wrap) begin
                pending <= 1'b0;
            end
        end
    end
endmodule
